neuron_input_streamer: RTL

NEURON_INPUT_STREAMER -- requirements
Module: neuron_input_streamer

---
 rtl/neuron_input_streamer.sv | 118 +++++++++++
 1 files changed

// File: rtl/neuron_input_streamer.sv
// Buffers one neuron pass worth of samples, then streams them out one per
// cycle with the freeze/pause handshake a neuron accumulator needs.
module neuron_input_streamer #(
  parameter int numWeight = 784,
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [dataWidth-1:0] in_data,
  output logic                 in_ready,
  input  logic                 start,
  output logic [dataWidth-1:0] myinput,
  output logic                 freeze,
  output logic                 pause,
  output logic                 busy,
  output logic                 result_valid
);

  localparam int IDX_W = (numWeight > 1) ? $clog2(numWeight) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numWeight - 1);

  typedef enum logic [2:0] {FILL, FULL, ARM, STREAM, RESULT} state_t;

  state_t               state, next_state;
  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic                 last_q;
  logic [dataWidth-1:0] sample_buf [numWeight];

  logic                 write_en;
  logic [IDX_W-1:0]     rd_addr;
  logic [dataWidth-1:0] myinput_d;
  logic                 freeze_d, pause_d, result_valid_d;

  assign write_en = (state == FILL) && in_valid;
  assign in_ready = (state == FILL);
  assign busy     = (state == ARM) || (state == STREAM);

  // Registered outputs are computed from next_state so they line up with
  // the state they belong to rather than lagging it by a cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    next_state     = state;
    rd_addr        = '0;
    myinput_d      = '0;
    freeze_d       = 1'b1;
    pause_d        = 1'b1;
    result_valid_d = 1'b0;

    case (state)
      FILL:    if (write_en && (wr_idx == LAST_IDX)) next_state = FULL;
      FULL:    if (start) next_state = ARM;
      ARM:     next_state = STREAM;
      STREAM:  if (last_q) next_state = RESULT;
      RESULT:  next_state = FILL;
      default: next_state = FILL;
    endcase

    if (state == STREAM) rd_addr = rd_idx;

    // ARM and the first STREAM cycle both present sample 0.
    if ((next_state == ARM) || (next_state == STREAM)) begin
      myinput_d = sample_buf[rd_addr];
      freeze_d  = 1'b0;
    end
    pause_d        = (next_state != STREAM);
    result_valid_d = (next_state == RESULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FILL;
      wr_idx       <= '0;
      rd_idx       <= '0;
      last_q       <= 1'b0;
      myinput      <= '0;
      freeze       <= 1'b1;
      pause        <= 1'b1;
      result_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state        <= next_state;
      myinput      <= myinput_d;
      freeze       <= freeze_d;
      pause        <= pause_d;
      result_valid <= result_valid_d;

      if (write_en) wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;

      // rd_idx is the sample fetched at the next edge; it parks on the last
      // index instead of wrapping, and last_q marks that it has been fetched.
      case (state)
        ARM: begin
          rd_idx <= IDX_W'(1);
          last_q <= 1'b0;
        end
        STREAM: begin
          if (!last_q) begin
            if (rd_idx == LAST_IDX) last_q <= 1'b1;
            else                    rd_idx <= rd_idx + 1'b1;
          end
        end
        RESULT: begin
          rd_idx <= '0;
          last_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the sample memory has no reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (write_en) sample_buf[wr_idx] <= in_data;
  end

endmodule
